// File: rtl/card_deal_ctrl.sv
// Card layout dealer: loads 8 pairs into 16 slots and shuffles them (LFSR-driven Fisher-Yates).
// Latency: start sampled at edge T, done pulses in the cycle after edge T+32 (15 DRAW/SWAP pairs).
// Backpressure: none; start while busy is dropped, and the layout is held until the next start.
// Optional build macro DEAL_FIXED_EN: LFSR reseeded on every start and frozen in IDLE, so every deal is identical.
module card_deal_ctrl #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [63:0] INIT_LOC  = 64'h0011_2233_4455_6677
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  ent_in,
  output logic        busy,
  output logic        done,
  output logic        loc_valid,
  output logic [63:0] card_loc
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_DRAW = 3'd2;
  localparam logic [2:0] ST_SWAP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]  state;
  logic [15:0] lfsr;
  logic [3:0]  idx;
  logic [3:0]  j_q;

  logic [15:0] lfsr_adv;
  logic [15:0] lfsr_seeded;
  logic [15:0] lfsr_idle;
  logic [3:0]  draw_mask;
  logic [3:0]  draw_r;
  logic [3:0]  draw_j;
  logic [63:0] card_swapped;

  assign busy = (state != ST_IDLE);

  // Galois step, right shift, taps 0xB400
  assign lfsr_adv = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

`ifdef DEAL_FIXED_EN
  // Reproducible deals: fixed seed on start, no free-running in IDLE
  assign lfsr_seeded = LFSR_SEED;
  assign lfsr_idle   = lfsr;
`else
  // Entropy fold-in on start; an all-zero result would lock the LFSR, so fall back to the seed
  logic [15:0] lfsr_mixed;
  assign lfsr_mixed  = lfsr ^ {8'h00, ent_in};
  assign lfsr_seeded = (lfsr_mixed == 16'h0000) ? LFSR_SEED : lfsr_mixed;
  assign lfsr_idle   = lfsr_adv;
`endif

  // Single-try draw of j in 0..idx: mask to the next 2^n-1, fold overshoot back into range
  always_comb begin
    draw_mask = 4'hF;
    if (idx < 4'd2)      draw_mask = 4'h1;
    else if (idx < 4'd4) draw_mask = 4'h3;
    else if (idx < 4'd8) draw_mask = 4'h7;
    else                 draw_mask = 4'hF;
    draw_r = lfsr[3:0] & draw_mask;
    draw_j = (draw_r <= idx) ? draw_r : (draw_r - (idx + 4'd1));
  end

  // Exchange nibbles idx and j_q; j_q == idx degenerates to no change
  always_comb begin
    card_swapped = card_loc;
    card_swapped[{idx, 2'b00} +: 4] = card_loc[{j_q, 2'b00} +: 4];
    card_swapped[{j_q, 2'b00} +: 4] = card_loc[{idx, 2'b00} +: 4];
  end

  // Deal sequencer: IDLE -> LOAD -> (DRAW -> SWAP) x15 -> DONE -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lfsr      <= LFSR_SEED;
      idx       <= 4'd15;
      j_q       <= 4'd0;
      card_loc  <= INIT_LOC;
      done      <= 1'b0;
      loc_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_LOAD;
            loc_valid <= 1'b0;
            lfsr      <= lfsr_seeded;
          end else begin
            lfsr <= lfsr_idle;
          end
        end
        ST_LOAD: begin
          card_loc <= INIT_LOC;
          idx      <= 4'd15;
          state    <= ST_DRAW;
        end
        ST_DRAW: begin
          j_q   <= draw_j;
          lfsr  <= lfsr_adv;
          state <= ST_SWAP;
        end
        ST_SWAP: begin
          card_loc <= card_swapped;
          if (idx == 4'd1) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx - 4'd1;
            state <= ST_DRAW;
          end
        end
        ST_DONE: begin
          done      <= 1'b1;
          loc_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_deal_ctrl.sv
// Directed and randomised checks of card_deal_ctrl against a reference deal model.
// Latency: checks the fixed 32-cycle start-to-done timing on every deal.
// Backpressure: none; exercises dropped starts during busy and held start after done.
module tb_card_deal_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [63:0] INIT = 64'h0011_2233_4455_6677;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  ent_in = 8'h00;
  logic        busy;
  logic        done;
  logic        loc_valid;
  logic [63:0] card_loc;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // reference model state
  logic [15:0] m_lfsr = SEED;
  int          m_cnt = 0;
  logic [63:0] m_exp = INIT;
  logic        poke = 1'b0;
  logic [15:0] poke_val = 16'h0000;

  card_deal_ctrl #(.LFSR_SEED(SEED), .INIT_LOC(INIT)) dut (
    .clk(clk), .rst(rst), .start(start), .ent_in(ent_in),
    .busy(busy), .done(done), .loc_valid(loc_valid), .card_loc(card_loc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] adv(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] mix_seed(input logic [15:0] cur, input logic [7:0] ent);
    logic [15:0] x;
    x = cur ^ {8'h00, ent};
`ifdef DEAL_FIXED_EN
    x = SEED;
`endif
    return (x == 16'h0000) ? SEED : x;
  endfunction

  function automatic logic [15:0] idle_next(input logic [15:0] cur);
`ifdef DEAL_FIXED_EN
    return cur;
`else
    return adv(cur);
`endif
  endfunction

  // Fisher-Yates over an unpacked array, one LFSR draw per slot from 15 down to 1
  function automatic logic [63:0] deal_loc(input logic [15:0] seed);
    logic [3:0]  a [16];
    logic [63:0] init_v;
    logic [63:0] res;
    logic [15:0] s;
    logic [3:0]  t;
    int m, r, j;
    init_v = INIT;
    s = seed;
    for (int k = 0; k < 16; k++) a[k] = init_v[k*4 +: 4];
    for (int i = 15; i >= 1; i--) begin
      m = (i >= 8) ? 15 : (i >= 4) ? 7 : (i >= 2) ? 3 : 1;
      r = int'(s[3:0]) & m;
      j = (r <= i) ? r : r - (i + 1);
      s = adv(s);
      t = a[i]; a[i] = a[j]; a[j] = t;
    end
    res = '0;
    for (int k = 0; k < 16; k++) res[k*4 +: 4] = a[k];
    return res;
  endfunction

  function automatic logic [15:0] deal_fin(input logic [15:0] seed);
    logic [15:0] s;
    s = seed;
    for (int i = 0; i < 15; i++) s = adv(s);
    return s;
  endfunction

  function automatic logic perm_ok(input logic [63:0] loc);
    int cnt [16];
    logic ok;
    for (int v = 0; v < 16; v++) cnt[v] = 0;
    for (int k = 0; k < 16; k++) cnt[loc[k*4 +: 4]]++;
    ok = 1'b1;
    for (int v = 0; v < 16; v++) if (cnt[v] != ((v < 8) ? 2 : 0)) ok = 1'b0;
    return ok;
  endfunction

  // cycle model: one deal predicted in full at the start edge, 32 busy cycles, free-run otherwise
  always @(posedge clk) begin
    if (rst) begin
      m_lfsr <= SEED;
      m_cnt  <= 0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_exp  <= deal_loc(mix_seed(poke ? poke_val : m_lfsr, ent_in));
        m_lfsr <= deal_fin(mix_seed(poke ? poke_val : m_lfsr, ent_in));
        m_cnt  <= 32;
      end else begin
        m_lfsr <= idle_next(poke ? poke_val : m_lfsr);
      end
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic run_deal(input logic [7:0] ent, output int lat, output int busy_cyc);
    int t0;
    @(negedge clk);
    start = 1'b1;
    ent_in = ent;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    busy_cyc = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = cyc - t0;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (card_loc !== INIT) begin fails++; $display("FAIL reset_card_loc got %h want %h", card_loc, INIT); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (loc_valid !== 1'b0) begin fails++; $display("FAIL reset_loc_valid got %b want 0", loc_valid); end
    rst = 1'b0;
  endtask

  task automatic test_single_deal;
    int lat, bc;
    logic [63:0] first;
    run_deal(8'h3C, lat, bc);
    tests++; if (lat !== 32) begin fails++; $display("FAIL single_latency got %0d want 32", lat); end
    tests++; if (bc !== 32) begin fails++; $display("FAIL single_busy_cycles got %0d want 32", bc); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_at_done got %b want 0", busy); end
    tests++; if (loc_valid !== 1'b1) begin fails++; $display("FAIL single_loc_valid got %b want 1", loc_valid); end
    tests++; if (card_loc !== m_exp) begin fails++; $display("FAIL single_card_loc got %h want %h", card_loc, m_exp); end
`ifdef DEAL_FIXED_EN
    tests++; if (card_loc !== deal_loc(16'hACE1)) begin fails++; $display("FAIL fixed_golden got %h want %h", card_loc, deal_loc(16'hACE1)); end
`endif
    first = card_loc;
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL single_done_width got %b want 0", done); end
    tests++; if (card_loc !== first) begin fails++; $display("FAIL single_loc_stable got %h want %h", card_loc, first); end
    repeat (3) @(negedge clk);
    run_deal(8'hA7, lat, bc);
    tests++; if (lat !== 32) begin fails++; $display("FAIL second_latency got %0d want 32", lat); end
    tests++; if (card_loc !== m_exp) begin fails++; $display("FAIL second_card_loc got %h want %h", card_loc, m_exp); end
`ifdef DEAL_FIXED_EN
    tests++; if (card_loc !== first) begin fails++; $display("FAIL fixed_repeat got %h want %h", card_loc, first); end
`endif
  endtask

  task automatic test_busy_ignore;
    int t0, ndone, dcyc;
    @(negedge clk);
    start = 1'b1;
    ent_in = 8'h5A;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    dcyc = -1;
    for (int k = 0; k < 45; k++) begin
      if (done) begin
        ndone++;
        dcyc = cyc - t0;
        tests++; if (card_loc !== m_exp) begin fails++; $display("FAIL ignore_card_loc got %h want %h", card_loc, m_exp); end
      end
      start = ((cyc - t0) == 4) || ((cyc - t0) == 19);
      @(negedge clk);
      start = 1'b0;
    end
    tests++; if (ndone !== 1) begin fails++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    tests++; if (dcyc !== 32) begin fails++; $display("FAIL ignore_latency got %0d want 32", dcyc); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_not_queued got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int lat, bc, ndone;
    @(negedge clk);
    start = 1'b1;
    ent_in = 8'hC3;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (card_loc !== INIT) begin fails++; $display("FAIL midrst_card_loc got %h want %h", card_loc, INIT); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", busy); end
    tests++; if (loc_valid !== 1'b0) begin fails++; $display("FAIL midrst_loc_valid got %b want 0", loc_valid); end
    tests++; if (dut.lfsr !== SEED) begin fails++; $display("FAIL midrst_lfsr got %h want %h", dut.lfsr, SEED); end
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    tests++; if (ndone !== 0) begin fails++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
    run_deal(8'h11, lat, bc);
    tests++; if (lat !== 32) begin fails++; $display("FAIL midrst_redeal_latency got %0d want 32", lat); end
    tests++; if (card_loc !== m_exp) begin fails++; $display("FAIL midrst_redeal_loc got %h want %h", card_loc, m_exp); end
  endtask

  task automatic test_back_to_back;
    int t0, d1, d2;
    @(negedge clk);
    start = 1'b1;
    ent_in = 8'h99;
    t0 = cyc + 1;
    d1 = -1;
    d2 = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else begin
          d2 = cyc;
          start = 1'b0;
          tests++; if (card_loc !== m_exp) begin fails++; $display("FAIL b2b_card_loc got %h want %h", card_loc, m_exp); end
          break;
        end
      end
    end
    start = 1'b0;
    tests++; if (d1 - t0 !== 32) begin fails++; $display("FAIL b2b_first_latency got %0d want 32", d1 - t0); end
    tests++; if (d2 - d1 !== 33) begin fails++; $display("FAIL b2b_retrigger_gap got %0d want 33", d2 - d1); end
    repeat (2) @(negedge clk);
  endtask

`ifndef DEAL_FIXED_EN
  task automatic test_zero_seed;
    int lat, bc;
    @(negedge clk);
    force dut.lfsr = 16'h0055;
    poke = 1'b1;
    poke_val = 16'h0055;
    start = 1'b1;
    ent_in = 8'h55;
    #1 release dut.lfsr;
    @(negedge clk);
    start = 1'b0;
    poke = 1'b0;
    tests++; if (dut.lfsr !== 16'hACE1) begin fails++; $display("FAIL zero_seed_lfsr got %h want ace1", dut.lfsr); end
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin lat = k; break; end
      @(negedge clk);
    end
    tests++; if (lat !== 32) begin fails++; $display("FAIL zero_seed_latency got %0d want 32", lat); end
    tests++; if (card_loc !== deal_loc(16'hACE1)) begin fails++; $display("FAIL zero_seed_loc got %h want %h", card_loc, deal_loc(16'hACE1)); end
    tests++; if (perm_ok(card_loc) !== 1'b1) begin fails++; $display("FAIL zero_seed_perm got %h not a pair permutation", card_loc); end
  endtask
`endif

  task automatic test_random;
    int lat, bc, gap;
    for (int n = 0; n < 1000; n++) begin
      gap = $urandom_range(0, 15);
      repeat (gap) @(negedge clk);
      run_deal(8'($urandom), lat, bc);
      tests++; if (lat !== 32) begin fails++; $display("FAIL rand_latency deal %0d got %0d want 32", n, lat); end
      tests++; if (perm_ok(card_loc) !== 1'b1) begin fails++; $display("FAIL rand_perm deal %0d got %h", n, card_loc); end
      tests++; if (card_loc !== m_exp) begin fails++; $display("FAIL rand_card_loc deal %0d got %h want %h", n, card_loc, m_exp); end
    end
  endtask

  initial begin
    test_reset;
    test_single_deal;
    test_busy_ignore;
    test_reset_mid;
    test_back_to_back;
`ifndef DEAL_FIXED_EN
    test_zero_seed;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
